// File: rtl/lpc_record_packer_pkg.sv
// Shared types and constants for the LPC record packer: the record layout,
// the frame geometry and the serializer states.
package lpc_pack_pkg;

    localparam logic [7:0] FRAME_HEADER = 8'h5A;
    localparam int         FRAME_BYTES  = 10;
    localparam int         RECORD_W     = 71;
    localparam int         INDEX_W      = 4;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    typedef struct packed {
        logic [3:0]  cyctype_dir;
        logic [2:0]  data_size;
        logic [31:0] addr;
        logic [31:0] data;
    } record_t;

    // Byte `idx` of the serialized frame; multi-byte fields go MSB first.
    function automatic logic [7:0] frame_byte(input record_t rec, input logic [INDEX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = FRAME_HEADER;
            4'd1:    b = {rec.cyctype_dir, 1'b0, rec.data_size};
            4'd2:    b = rec.addr[31:24];
            4'd3:    b = rec.addr[23:16];
            4'd4:    b = rec.addr[15:8];
            4'd5:    b = rec.addr[7:0];
            4'd6:    b = rec.data[31:24];
            4'd7:    b = rec.data[23:16];
            4'd8:    b = rec.data[15:8];
            4'd9:    b = rec.data[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lpc_record_fifo.sv
// Show-ahead synchronous FIFO of captured LPC records; the extra pointer MSB
// tells full from empty when the low bits match.
module lpc_record_fifo
    import lpc_pack_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                lpc_clock,
    input  logic                lpc_reset,
    input  logic                wr_en,
    input  logic [RECORD_W-1:0] wr_data,
    input  logic                rd_en,
    output logic [RECORD_W-1:0] rd_data,
    output logic                empty,
    output logic                full
);

    localparam int AW = $clog2(DEPTH);

    logic [RECORD_W-1:0] mem [DEPTH];
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone define what is valid,
    // so clearing the array would only cost flops and reset fan-out.
    always_ff @(posedge lpc_clock) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/lpc_record_packer.sv
// Captures decoded LPC transactions into a record FIFO and serializes each
// record as a 10-byte ready/valid frame for the transport stage.
module lpc_record_packer
    import lpc_pack_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        lpc_clock,
    input  logic        lpc_reset,
    input  logic [3:0]  in_cyctype_dir,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic [2:0]  in_data_size,
    input  logic        in_valid,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        fifo_empty,
    output logic [7:0]  overflow_count
);

    localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(FRAME_BYTES - 1);

    record_t              in_rec;
    record_t              head_rec;
    record_t              frame;
    state_t               state;
    state_t               next_state;
    logic [INDEX_W-1:0]   index;
    logic [INDEX_W-1:0]   next_index;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic                 empty;
    logic                 full;

    assign in_rec = {in_cyctype_dir, in_data_size, in_addr, in_data};

    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    lpc_record_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .lpc_clock (lpc_clock),
        .lpc_reset (lpc_reset),
        .wr_en     (push),
        .wr_data   (in_rec),
        .rd_en     (pop),
        .rd_data   (head_rec),
        .empty     (empty),
        .full      (full)
    );

    // NOTE: every output of this block gets a default first so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        next_index = index;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_index = '0;
                    next_state = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (index == LAST_INDEX) begin
                        next_index = '0;
                        if (!empty) pop = 1'b1;
                        else        next_state = IDLE;
                    end else begin
                        next_index = index + 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            state          <= IDLE;
            index          <= '0;
            frame          <= '0;
            overflow_count <= 8'h00;
        end else begin
            state <= next_state;
            index <= next_index;
            if (pop) frame <= head_rec;
            if (drop && overflow_count != 8'hFF) overflow_count <= overflow_count + 8'd1;
        end
    end

    assign out_valid  = (state == SEND);
    assign out_byte   = out_valid ? frame_byte(frame, index) : 8'h00;
    assign fifo_empty = empty;

endmodule

// File: doc/lpc_record_packer.md
# lpc_record_packer

Downstream stage of the `lpc` decoder. It captures each decoded LPC transaction, meaning cycle type/direction, address, data and size, on the decoder's clock-enable pulse. Captured transactions are buffered in a small record FIFO. Each record is then serialized as a fixed 10-byte frame on a ready/valid byte stream that feeds the UART/transport stage.

## Interface
Parameters:
- `DEPTH`, 8: record FIFO depth; must be a power of two, 2..64.

Ports:
- `lpc_clock`  in  1  LPC clock; the only clock.
- `lpc_reset`  in  1  reset, asynchronous, active-low.
- `in_cyctype_dir`  in  4  cycle type/direction, from `out_cyctype_dir`.
- `in_addr`  in  32  transaction address, from `out_addr`.
- `in_data`  in  32  transaction data, from `out_data`.
- `in_data_size`  in  3  size code, from `out_data_size`.
- `in_valid`  in  1  one-cycle capture strobe, from `out_clock_enable`.
- `out_byte`  out  8  serialized frame byte.
- `out_valid`  out  1  `out_byte` is valid.
- `out_ready`  in  1  consumer accepts the byte.
- `fifo_empty`  out  1  no records are buffered.
- `overflow_count`  out  8  dropped records; saturates at 255.

## Operation
- Record layout is 71 bits: {cyctype_dir[3:0], data_size[2:0], addr[31:0], data[31:0]}.
- Frame format, in transmit order:
  - byte 0: header 0x5A;
  - byte 1: {cyctype_dir, 1'b0, data_size};
  - bytes 2-5: addr, MSB first;
  - bytes 6-9: data, MSB first.
- Capture: `in_valid` is sampled on each rising edge. If the FIFO is not full, or a pop occurs on the same edge, the record is written. Otherwise it is dropped and `overflow_count` increments, saturating at 255.
- Serializer state machine:
  - IDLE: when the FIFO is non-empty, pop the head into the frame register, set index to 0, go to SEND.
  - SEND: `out_valid` = 1 and `out_byte` = frame byte[index]. On handshake (`out_valid` & `out_ready`), index increments.
  - On the handshake of byte 9: if the FIFO is non-empty, pop the next record and restart at index 0 with no idle cycle. Otherwise go to IDLE.
- Back-pressure: while `out_valid` & !`out_ready`, `out_byte` and the index hold stable. Captures continue into the FIFO.
- Data is passed through unmodified. The packer does not mask by `data_size`.
- FIFO pointers are log2(DEPTH)+1 bits wide. Wrap-around is handled by the extra MSB: full when the MSBs differ and the low bits are equal.

## Timing
- Reset (async assert, synchronous release), every output:
  - `out_valid` = 0;
  - `out_byte` = 0x00;
  - `fifo_empty` = 1;
  - `overflow_count` = 0.
- Reset also clears the FIFO and puts the state machine in IDLE.
- Reset mid-frame abandons the frame and all buffered records. No partial frame resumes after reset.
- Latency: `in_valid` sampled at edge k with the FIFO empty and the state machine in IDLE:
  - `fifo_empty` falls after edge k;
  - pop happens at edge k+1;
  - `out_valid` = 1 with byte 0x5A after edge k+1.
- Throughput: one byte per cycle while `out_ready` = 1. Consecutive frames are gapless.
- Simultaneous write and pop with the FIFO full: the write is accepted and occupancy is unchanged.
- Simultaneous write and pop with the FIFO empty: cannot occur, because a pop requires a non-empty FIFO before the edge.
- `overflow_count` updates on the same edge as the dropped `in_valid`.

## Structure
- Package `lpc_pack_pkg` contains:
  - `FRAME_HEADER` = 8'h5A;
  - `FRAME_BYTES` = 10;
  - `RECORD_W` = 71;
  - the state enum {IDLE, SEND}.
- Sub-module `lpc_record_fifo`: synchronous FIFO of `RECORD_W` × `DEPTH` with write/pop, `empty`, `full`, and the same clock and reset.
- The top level holds the capture/overflow logic, the frame register, the index counter and the state machine.

## Test plan
- Single record, 16-bit memory read: cyctype_dir=4, size=2, addr=0xAFFE7FE5, data=0x0000DF6C, `out_ready`=1 → bytes 5A 42 AF FE 7F E5 00 00 DF 6C on 10 consecutive cycles, then `out_valid`=0 and `fifo_empty`=1.
- Back-pressure: same record, `out_ready` held low for 5 cycles while byte 4 (0x7F) is presented → `out_byte` stays 0x7F and `out_valid` stays 1; the frame then completes in order.
- Overflow: `out_ready`=0, DEPTH+3 distinct records → one record sits in the frame register, DEPTH are buffered, `overflow_count`=2. Release `out_ready` → (DEPTH+1)×10 bytes drain in capture order with no gaps.
- Back-to-back: two records one cycle apart, `out_ready`=1 → 20 consecutive valid bytes; byte 10 = 0x5A.
- Full plus simultaneous pop: FIFO full, `in_valid` on the same edge as a frame-end pop → record accepted, `overflow_count` unchanged.
- Reset mid-frame: assert `lpc_reset` low during byte 3 → `out_valid` = 0 immediately and `fifo_empty` = 1. A new record after release starts with 0x5A.
